// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath/memory port.
// The master side is the controller; the slave side is the datapath.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_we;
    logic             pc_we;
    logic             reg_we;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [1:0]       result_src;
    logic [1:0]       imm_src;
    logic             trap;
    logic             retired;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state_o;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, reg_we,
               alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src,
               trap, retired, instret, state_o
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, reg_we,
               alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src,
               trap, retired, instret, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences each instruction over a shared, variable-latency
// memory port, with memory-timeout and illegal-instruction traps and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic       reg_we;
        logic       retired;
        logic       trap;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] result_src;
        logic [1:0] imm_src;
    } ctl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int unsigned     WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    ctl_t               ctl;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               in_mem;
    logic               timed_out;
    logic               unused_instr;

    assign opcode       = bus.instr[6:0];
    assign funct3       = bus.instr[14:12];
    assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
    assign in_mem       = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
    // The access that completes on the limit cycle wins over the timeout.
    assign timed_out    = (TIMEOUT != 0) && in_mem && !bus.mem_ready && (wait_q == WAIT_LIM);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d = state_q;
        ctl     = '0;
        unique case (state_q)
            S_FETCH: begin
                ctl.mem_req    = 1'b1;
                ctl.alu_src_b  = 2'b10;
                ctl.result_src = 2'b10;
                if (bus.mem_ready) begin
                    ctl.ir_we = 1'b1;
                    ctl.pc_we = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b01;
                ctl.imm_src   = (opcode == OP_JAL) ? 2'b11 : 2'b10;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
                if (opcode == OP_STORE) begin
                    ctl.imm_src = 2'b01;
                    state_d     = S_MEMWRITE;
                end else begin
                    state_d     = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                ctl.mem_req = 1'b1;
                ctl.iord    = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.reg_we     = 1'b1;
                ctl.result_src = 2'b01;
                ctl.retired    = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                ctl.mem_req = 1'b1;
                ctl.mem_we  = 1'b1;
                ctl.iord    = 1'b1;
                if (bus.mem_ready) begin
                    ctl.retired = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                state_d       = S_ALUWB;
                case (funct3)
                    3'b000:  ctl.alu_ctrl = (state_q == S_EXECR && bus.instr[30]) ? 3'b001 : 3'b000;
                    3'b111:  ctl.alu_ctrl = 3'b010;
                    3'b110:  ctl.alu_ctrl = 3'b011;
                    3'b010:  ctl.alu_ctrl = 3'b101;
                    default: state_d      = S_TRAP;
                endcase
            end
            S_ALUWB: begin
                ctl.reg_we  = 1'b1;
                ctl.retired = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_ctrl  = 3'b001;
                if (funct3[2:1] != 2'b00) begin
                    state_d = S_TRAP;
                end else begin
                    ctl.pc_we   = bus.zero ^ funct3[0];
                    ctl.retired = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_JAL: begin
                ctl.pc_we     = 1'b1;
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b10;
                state_d       = S_ALUWB;
            end
            S_TRAP:  ctl.trap = 1'b1;
            default: state_d  = S_TRAP;
        endcase

        if (timed_out) state_d = S_TRAP;

        // Wait counter restarts whenever a state is entered and counts only stalled memory cycles.
        if (state_d != state_q)            wait_d = '0;
        else if (in_mem && !bus.mem_ready) wait_d = wait_q + WAIT_W'(1);
        else                               wait_d = wait_q;

        instret_d = instret_q + CNT_W'(ctl.retired);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values together.
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // Reset gates the outputs combinationally so an in-flight access drops immediately.
    ctl_t ctl_o;
    assign ctl_o          = rst ? ctl : '0;
    assign bus.mem_req    = ctl_o.mem_req;
    assign bus.mem_we     = ctl_o.mem_we;
    assign bus.iord       = ctl_o.iord;
    assign bus.ir_we      = ctl_o.ir_we;
    assign bus.pc_we      = ctl_o.pc_we;
    assign bus.reg_we     = ctl_o.reg_we;
    assign bus.retired    = ctl_o.retired;
    assign bus.trap       = ctl_o.trap;
    assign bus.alu_src_a  = ctl_o.alu_src_a;
    assign bus.alu_src_b  = ctl_o.alu_src_b;
    assign bus.alu_ctrl   = ctl_o.alu_ctrl;
    assign bus.result_src = ctl_o.result_src;
    assign bus.imm_src    = ctl_o.imm_src;
    assign bus.instret    = rst ? instret_q : '0;
    assign bus.state_o    = rst ? state_q : S_FETCH;

endmodule
